// File: rtl/serv_dbus_ram.sv
// rtl/serv_dbus_ram.sv - Wishbone classic data-bus RAM responder for the serial core, optional wait states
// Optional byte-select legality checker: define SERV_DBUS_SELCHK_EN.
module serv_dbus_ram #(
   parameter int    DEPTH   = 256,
   parameter int    AW      = $clog2(DEPTH),
   parameter int    WAIT    = 0,
   parameter string MEMFILE = ""
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [31:0] i_wb_adr,
   input  logic [31:0] i_wb_dat,
   input  logic [3:0]  i_wb_sel,
   input  logic        i_wb_we,
   input  logic        i_wb_cyc,
   output logic [31:0] o_wb_rdt,
   output logic        o_wb_ack,
   output logic        o_wb_err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_RESP
   } state_t;

   state_t          state;
   state_t          state_d;
   logic [3:0]      cnt;
   logic [3:0]      cnt_d;
   logic [31:0]     mem [DEPTH];
   logic [AW-1:0]   idx;
   logic            enter_resp;
   logic            sel_ok;
   logic            unused_adr;

   // Only the word index matters; byte offset and high bits alias onto the array.
   assign idx        = i_wb_adr[AW+1:2];
   assign unused_adr = ^{i_wb_adr[31:AW+2], i_wb_adr[1:0]};

`ifdef SERV_DBUS_SELCHK_EN
   always_comb begin
      sel_ok = 1'b0;
      case (i_wb_sel)
         4'b0001, 4'b0010, 4'b0100, 4'b1000,
         4'b0011, 4'b1100, 4'b1111: sel_ok = 1'b1;
         default:                   sel_ok = 1'b0;
      endcase
   end
`else
   assign sel_ok = 1'b1;
`endif

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      case (state)
         S_IDLE: begin
            if (i_wb_cyc) begin
               if (WAIT == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT);
               end
            end
         end
         S_WAIT: begin
            cnt_d = cnt - 4'd1;
            if (!i_wb_cyc) begin
               // Initiator gave up: no RAM access, no response.
               state_d = S_IDLE;
               cnt_d   = 4'd0;
            end else if (cnt == 4'd1) begin
               state_d = S_RESP;
            end
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign enter_resp = (state_d == S_RESP);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= S_IDLE;
         cnt      <= 4'd0;
         o_wb_ack <= 1'b0;
         o_wb_rdt <= 32'd0;
      end else begin
         state    <= state_d;
         cnt      <= cnt_d;
         o_wb_ack <= enter_resp && sel_ok;
         if (enter_resp && !i_wb_we && sel_ok) begin
            o_wb_rdt <= mem[idx];
         end
      end
   end

`ifdef SERV_DBUS_SELCHK_EN
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wb_err <= 1'b0;
      end else begin
         o_wb_err <= enter_resp && !sel_ok;
      end
   end
`else
   assign o_wb_err = 1'b0;
`endif

   // RAM contents survive reset; only selected lanes are written.
   always_ff @(posedge i_clk) begin
      if (enter_resp && i_wb_we && sel_ok) begin
         for (int n = 0; n < 4; n++) begin
            if (i_wb_sel[n]) begin
               mem[idx][8*n +: 8] <= i_wb_dat[8*n +: 8];
            end
         end
      end
   end

endmodule
